spdif_encoder: RTL and testbench

- Transmitter counterpart to the team's S/PDIF receiver: accepts parallel 24-bit stereo PCM samples over a valid/ready handshake.
- Emits an IEC 60958 consumer-format biphase-mark (BMC) serial stream on one output pin.
- Generates B/M/W preambles, V/U/C/P bits and 192-frame block framing.
- Sits on the transmit side of the top level and drives a uo_out pin; the receiver on a second board loops back to it.

---
 rtl/spdif_pkg.sv | 16 +
 rtl/spdif_bmc_encoder.sv | 29 ++
 rtl/spdif_encoder.sv | 95 +++++++++
 tb/tb_spdif_encoder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// spdif_pkg: shared constants and types for the S/PDIF transmitter.
// CHSTAT_CONST is only referenced when SPDIF_CHSTAT_EN is defined.
package spdif_pkg;
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;
    localparam logic [4:0] SLOT_AUX_LSB = 5'd4;
    localparam logic [4:0] SLOT_V = 5'd28;
    localparam logic [4:0] SLOT_U = 5'd29;
    localparam logic [4:0] SLOT_C = 5'd30;
    localparam logic [4:0] SLOT_P = 5'd31;
    localparam int DEF_BLOCK_FRAMES = 192;
    // consumer, PCM, copy permitted, 48 kHz, 24-bit word length
    localparam logic [191:0] CHSTAT_CONST = 192'hB_0200_0004;
    typedef enum logic {SF_L, SF_R} subframe_e;
endpackage

// File: rtl/spdif_bmc_encoder.sv
// spdif_bmc_encoder: biphase-mark line driver with raw preamble insertion.
// Preamble UIs are the pattern XORed with the line level held before the preamble.
module spdif_bmc_encoder (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       ui_stb_i,
    input  logic       pre_i,
    input  logic       half_i,
    input  logic       bit_i,
    input  logic [7:0] pat_i,
    input  logic [2:0] idx_i,
    output logic       tx_o
);
    logic tx_q, tx_d, base_q, base_d;
    always_comb begin
        base_d = (ui_stb_i && pre_i && idx_i == 3'd0) ? tx_q : base_q;
        tx_d = !ui_stb_i ? tx_q : pre_i ? pat_i[3'd7 - idx_i] ^ base_d : half_i ? tx_q ^ bit_i : ~tx_q;
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            tx_q <= 1'b0;
            base_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
            base_q <= base_d;
        end
    end
    assign tx_o = tx_q;
endmodule

// File: rtl/spdif_encoder.sv
// spdif_encoder: IEC 60958 consumer S/PDIF transmitter with one-deep sample holding register.
// Define SPDIF_CHSTAT_EN to send CHSTAT_CONST as channel status; otherwise C is always 0.
module spdif_encoder
    import spdif_pkg::*;
#(
    parameter int UI_DIV = 4,
    parameter int BLOCK_FRAMES = DEF_BLOCK_FRAMES
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [23:0] sample_l,
    input  logic [23:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        tx_out,
    output logic        block_start,
    output logic        underrun
);
    localparam int UW = $clog2(UI_DIV);
    localparam int FW = $clog2(BLOCK_FRAMES);
    logic [UW-1:0] ui_cnt_q, ui_cnt_d;
    logic [5:0]    pos_q, pos_d;
    subframe_e     sf_q, sf_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [47:0]   hold_q, hold_d, sh_q, sh_d;
    logic          full_q, full_d, v_q, v_d, par_q, par_d, bs_q, ur_q;
    logic          ui_stb, ui_end, load, xfer, cell_bit, c_bit;
    logic [4:0]    slot;
    logic [7:0]    pat;
    always_comb begin
        slot = pos_q[5:1];
        ui_stb = ui_cnt_q == '0;
        ui_end = ui_cnt_q == UW'(UI_DIV - 1);
        load = ui_stb && pos_q == 6'd0 && sf_q == SF_L;
        sample_ready = !full_q || load;
        xfer = sample_valid && sample_ready;
`ifdef SPDIF_CHSTAT_EN
        c_bit = CHSTAT_CONST[frame_q];
`else
        c_bit = 1'b0;
`endif
        cell_bit = slot == SLOT_P ? par_q : slot == SLOT_C ? c_bit : slot == SLOT_U ? 1'b0 : slot == SLOT_V ? v_q : sh_q[0];
        pat = sf_q == SF_R ? PRE_W : frame_q == '0 ? PRE_B : PRE_M;
        ui_cnt_d = ui_end ? '0 : ui_cnt_q + 1'b1;
        pos_d = ui_end ? pos_q + 6'd1 : pos_q;
        sf_d = (ui_end && pos_q == 6'd63) ? (sf_q == SF_L ? SF_R : SF_L) : sf_q;
        frame_d = (ui_end && pos_q == 6'd63 && sf_q == SF_R) ? (frame_q == FW'(BLOCK_FRAMES - 1) ? '0 : frame_q + 1'b1) : frame_q;
        full_d = load ? xfer : full_q || xfer;
        hold_d = xfer ? {sample_r, sample_l} : hold_q;
        // {R, L} shifts out LSB first; after 24 cells the R sample sits at the bottom
        sh_d = load ? (full_q ? hold_q : '0) : (ui_stb && pos_q[0] && slot >= SLOT_AUX_LSB && slot < SLOT_V) ? sh_q >> 1 : sh_q;
        v_d = load ? !full_q : v_q;
        par_d = (!ui_stb || pos_q[0]) ? par_q : slot < SLOT_AUX_LSB ? 1'b0 : slot < SLOT_P ? par_q ^ cell_bit : par_q;
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            ui_cnt_q <= '0;
            pos_q <= '0;
            sf_q <= SF_L;
            frame_q <= '0;
            hold_q <= '0;
            sh_q <= '0;
            full_q <= 1'b0;
            v_q <= 1'b0;
            par_q <= 1'b0;
            bs_q <= 1'b0;
            ur_q <= 1'b0;
        end else begin
            ui_cnt_q <= ui_cnt_d;
            pos_q <= pos_d;
            sf_q <= sf_d;
            frame_q <= frame_d;
            hold_q <= hold_d;
            sh_q <= sh_d;
            full_q <= full_d;
            v_q <= v_d;
            par_q <= par_d;
            bs_q <= load && frame_q == '0;
            ur_q <= load && !full_q;
        end
    end
    assign block_start = bs_q;
    assign underrun = ur_q;
    spdif_bmc_encoder u_bmc (
        .clk_in  (clk_in),
        .reset   (reset),
        .ui_stb_i(ui_stb),
        .pre_i   (slot < SLOT_AUX_LSB),
        .half_i  (pos_q[0]),
        .bit_i   (cell_bit),
        .pat_i   (pat),
        .idx_i   (pos_q[2:0]),
        .tx_o    (tx_out)
    );
endmodule

// File: tb/tb_spdif_encoder.sv
// tb_spdif_encoder: randomized bench comparing the S/PDIF line against a frame-level reference model.
// Honours SPDIF_CHSTAT_EN for the expected channel-status bits.
module tb_spdif_encoder;
    localparam int UI_DIV = 2;
    localparam int FRAME_CLK = 128 * UI_DIV;
    localparam int NFR = 192;
    logic clk_in = 1'b0;
    logic reset = 1'b1;
    logic [23:0] sample_l = '0, sample_r = '0;
    logic sample_valid = 1'b0;
    logic sample_ready, tx_out, block_start, underrun;
    always #5 clk_in = ~clk_in;
    spdif_encoder #(.UI_DIV(UI_DIV)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .tx_out      (tx_out),
        .block_start (block_start),
        .underrun    (underrun)
    );
    int total = 0, bad = 0;
    int j, mode, bs_count, bs_last, bs_period;
    logic hold_full, line, ur_exp, bs_exp;
    logic [23:0] hold_l, hold_r;
    logic [127:0] exp_ui, obs_a, obs_b;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic chstat(input int f);
`ifdef SPDIF_CHSTAT_EN
        return f == 2 || f == 25 || f == 32 || f == 33 || f == 35;
`else
        return 1'b0;
`endif
    endfunction
    // line levels of one subframe, first UI in the MSB
    function automatic logic [63:0] sub_ui(input logic [7:0] pre, input logic [23:0] s, input logic v, input logic c, input logic lv0);
        logic [27:0] bits;
        logic [63:0] u;
        logic lv;
        bits = {^{s, v, c}, c, 1'b0, v, s};
        for (int i = 0; i < 8; i++) u[63-i] = pre[7-i] ^ lv0;
        lv = pre[0] ^ lv0;
        for (int k = 0; k < 28; k++) begin
            lv = ~lv;
            u[55-2*k] = lv;
            if (bits[k]) lv = ~lv;
            u[54-2*k] = lv;
        end
        return u;
    endfunction
    task automatic release_reset();
        reset = 1'b0;
        j = -1;
        hold_full = 1'b0;
        line = 1'b0;
        bs_count = 0;
        bs_last = -1;
        bs_period = 0;
    endtask
    task automatic step();
        int m, o, f;
        logic is_load, rdy_exp, xfer;
        logic [63:0] ul, ur;
        m = j + 1;
        o = m % FRAME_CLK;
        is_load = o == 0;
        rdy_exp = !hold_full || is_load;
        check("ready", 128'(sample_ready), 128'(rdy_exp));
        case (mode)
            0: begin sample_valid = 1'b1; sample_l = 24'h000001; sample_r = 24'h800000; end
            1: sample_valid = 1'b0;
            2: begin sample_valid = $urandom_range(0, 199) == 0; sample_l = 24'($urandom()); sample_r = 24'($urandom()); end
            default: begin sample_valid = o == 0 || o == 100; sample_l = 24'($urandom()); sample_r = 24'($urandom()); end
        endcase
        xfer = sample_valid && rdy_exp;
        ur_exp = is_load && !hold_full;
        f = (m / FRAME_CLK) % NFR;
        bs_exp = is_load && f == 0;
        if (is_load) begin
            ul = sub_ui(f == 0 ? 8'b11101000 : 8'b11100010, hold_full ? hold_l : 24'h0, !hold_full, chstat(f), line);
            ur = sub_ui(8'b11100100, hold_full ? hold_r : 24'h0, !hold_full, chstat(f), ul[0]);
            exp_ui = {ul, ur};
            line = ur[0];
            hold_full = xfer;
        end else if (xfer) hold_full = 1'b1;
        if (xfer) begin
            hold_l = sample_l;
            hold_r = sample_r;
        end
        @(posedge clk_in);
        j++;
        @(negedge clk_in);
        check("flags", 128'({block_start, underrun}), 128'({bs_exp, ur_exp}));
        if (block_start) begin
            if (bs_last >= 0) bs_period = j - bs_last;
            bs_last = j;
            bs_count++;
        end
        o = (j % FRAME_CLK) / UI_DIV;
        if (j % UI_DIV == 0) obs_a[127-o] = tx_out;
        if (j % UI_DIV == UI_DIV - 1) obs_b[127-o] = tx_out;
        if (j % FRAME_CLK == FRAME_CLK - 1) begin
            check($sformatf("frame%0d_early", j / FRAME_CLK), obs_a, exp_ui);
            check($sformatf("frame%0d_late", j / FRAME_CLK), obs_b, exp_ui);
        end
    endtask
    initial begin
        repeat (3) @(negedge clk_in);
        check("reset_state", 128'({tx_out, sample_ready, block_start, underrun}), 128'(4'b0100));
        release_reset();
        mode = 0;
        repeat (3 * FRAME_CLK) step();
        mode = 1;
        repeat (3 * FRAME_CLK) step();
        mode = 3;
        repeat (7 * FRAME_CLK) step();
        mode = 2;
        while (j < 57 * FRAME_CLK + 60) step();
        reset = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        check("reset_mid", 128'({tx_out, sample_ready, block_start, underrun}), 128'(4'b0100));
        repeat (2) @(negedge clk_in);
        release_reset();
        mode = 2;
        while (j < NFR * FRAME_CLK + 4) step();
        check("bs_count", 128'(bs_count), 128'(2));
        check("bs_period", 128'(bs_period), 128'(NFR * FRAME_CLK));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
